// File: rtl/fact_pkg.sv
// Shared definitions for the sequential factorial block: FSM state
// encoding and the default operand/result widths.
package fact_pkg;

   localparam int unsigned IN_W_DEF  = 8;
   localparam int unsigned OUT_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fact_mul.sv
// Combinational OUT_W x IN_W multiplier. The product is formed at full
// OUT_W+IN_W width; the low OUT_W bits are returned and any set bit
// above them is reported on ovf.
module fact_mul #(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned OUT_W = 32
)(
   input  logic [OUT_W-1:0] a,
   input  logic [IN_W-1:0]  b,
   output logic [OUT_W-1:0] p,
   output logic             ovf
);

   logic [OUT_W+IN_W-1:0] full;

   // full-width product, then split into kept bits and overflow indication
   always_comb begin
      full = {{IN_W{1'b0}}, a} * {{OUT_W{1'b0}}, b};
      p    = full[OUT_W-1:0];
      ovf  = |full[OUT_W+IN_W-1:OUT_W];
   end

endmodule

// File: rtl/seq_factorial.sv
// Sequential factorial: one multiply per cycle, acc <= acc*cnt,
// cnt counting down from the captured operand to 2.
// Optional build macro FACT_SAT_EN: on overflow the result saturates to
// all-ones instead of carrying the truncated product chain.
module seq_factorial
   import fact_pkg::*;
#(
   parameter int unsigned IN_W  = IN_W_DEF,
   parameter int unsigned OUT_W = OUT_W_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IN_W-1:0]  num,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] result,
   output logic             overflow
);

   state_t           state;
   logic [OUT_W-1:0] acc;
   logic [IN_W-1:0]  cnt;
   logic             ovf_sticky;

   logic [IN_W-1:0]  mul_b;
   logic [OUT_W-1:0] prod;
   logic             prod_ovf;
   logic             sticky_n;

   // Operands 0 and 1 take a single CALC pass multiplying by 1, which
   // yields result 1 with the required one-cycle latency.
   always_comb begin
      mul_b    = (cnt < IN_W'(2)) ? IN_W'(1) : cnt;
      sticky_n = ovf_sticky | prod_ovf;
   end

   fact_mul #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_mul (
      .a   (acc),
      .b   (mul_b),
      .p   (prod),
      .ovf (prod_ovf)
   );

   // control FSM with registered busy/done/result/overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         overflow   <= 1'b0;
         acc        <= '0;
         cnt        <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  acc        <= OUT_W'(1);
                  cnt        <= num;
                  busy       <= 1'b1;
                  overflow   <= 1'b0;
                  ovf_sticky <= 1'b0;
                  state      <= CALC;
               end
            end
            CALC: begin
               acc        <= prod;
               cnt        <= cnt - IN_W'(1);
               ovf_sticky <= sticky_n;
               if (cnt <= IN_W'(2)) begin
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  overflow <= sticky_n;
`ifdef FACT_SAT_EN
                  result   <= sticky_n ? '1 : prod;
`else
                  result   <= prod;
`endif
                  state    <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_factorial.sv
// Self-checking bench for seq_factorial: a transaction-level model
// (factorial arithmetic plus a latency countdown) checked every cycle,
// directed cases with literal expectations, then random traffic.
module tb_seq_factorial;

   localparam int unsigned IN_W  = 8;
   localparam int unsigned OUT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [IN_W-1:0]  num;
   logic             busy;
   logic             done;
   logic [OUT_W-1:0] result;
   logic             overflow;

   int checks = 0;
   int errors = 0;
   bit go = 1'b0;

   seq_factorial #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .num      (num),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // factorial with the result kept to OUT_W bits; ov marks a true value
   // that no longer fits in OUT_W bits
   function automatic logic [OUT_W-1:0] fact_ref(input int n, output bit ov);
      longint unsigned p;
      p  = 1;
      ov = 1'b0;
      for (int k = 2; k <= n; k++) begin
         p = p * longint'(k);
         if ((p >> OUT_W) != 0) ov = 1'b1;
         p = p & ((64'd1 << OUT_W) - 1);
      end
`ifdef FACT_SAT_EN
      if (ov) p = (64'd1 << OUT_W) - 1;
`endif
      return p[OUT_W-1:0];
   endfunction

   // transaction-level model state
   bit               m_busy, m_done, m_ovf, p_ovf;
   logic [OUT_W-1:0] m_result, p_res;
   int               rem;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_ovf = 0; m_result = '0; rem = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (!m_busy && start) begin
         p_res  = fact_ref(int'(num), p_ovf);
         rem    = (int'(num) > 2) ? int'(num) - 1 : 1;
         m_busy = 1;
         m_ovf  = 0;
      end else if (m_busy) begin
         rem--;
         if (rem == 0) begin
            m_busy   = 0;
            m_done   = 1;
            m_result = p_res;
            m_ovf    = p_ovf;
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (go) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("overflow", overflow, m_ovf);
         chk("result", result, m_result);
      end
   end

   task automatic run(input int n, input logic [OUT_W-1:0] er, input bit eo, input int el);
      int cyc;
      bit seen;
      @(negedge clk);
      num   = IN_W'(n);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc  = 0;
      seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(posedge clk);
         #1 cyc++;
         if (done) seen = 1;
      end
      chk($sformatf("done_seen_n%0d", n), seen, 1);
      chk($sformatf("result_n%0d", n), result, er);
      chk($sformatf("overflow_n%0d", n), overflow, eo);
      chk($sformatf("latency_n%0d", n), cyc, el);
      @(negedge clk);
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(posedge clk);
         #1 if (done) seen = 1;
      end
      chk(name, seen, 1);
   endtask

   initial begin
      bit ov;
      logic [OUT_W-1:0] r13;
      int ndone;

      rst = 1'b1; start = 1'b0; num = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_overflow", overflow, 0);
      @(negedge clk);
      rst = 1'b0;
      go  = 1'b1;

      // pin the model itself with hand-computed values
      chk("model_5", fact_ref(5, ov), 120);
      chk("model_12", fact_ref(12, ov), 479001600);
      r13 = fact_ref(13, ov);
      chk("model_13_ov", ov, 1);
`ifdef FACT_SAT_EN
      chk("model_13", r13, 32'hFFFF_FFFF);
`else
      chk("model_13", r13, 32'd1932053504);
`endif

      run(5, 120, 0, 4);
      run(0, 1, 0, 1);
      run(1, 1, 0, 1);
      run(2, 2, 0, 1);
      run(12, 479001600, 0, 11);
      run(7, 5040, 0, 6);
`ifdef FACT_SAT_EN
      run(13, 32'hFFFF_FFFF, 1, 12);
`else
      run(13, 32'd1932053504, 1, 12);
`endif
      run(3, 6, 0, 2);

      // start during busy: second request ignored
      @(negedge clk);
      num = 8'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      num = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("done_seen_ignore");
      chk("result_ignore", result, 720);

      // start held through the DONE cycle: accepted from the next IDLE cycle
      @(negedge clk);
      num = 8'd4; start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done("done_seen_after_done_start");
      chk("result_after_done_start", result, 24);

      // reset mid-computation abandons it
      @(negedge clk);
      num = 8'd10; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      chk("midrst_overflow", overflow, 0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1 if (done) ndone++;
      end
      chk("no_done_after_rst", ndone, 0);
      run(4, 24, 0, 3);

      // random traffic, including start noise while busy and large operands
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         num   = ($urandom_range(0, 7) == 0) ? IN_W'($urandom_range(0, 255))
                                             : IN_W'($urandom_range(0, 16));
      end
      @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
